rsa_mont_wrapper: RTL and testbench

Command-driven accelerator wrapper between the ARM host interface and a 512-bit radix-2 Montgomery multiplier. The host issues 32-bit commands to load operands (A and B packed in one 1024-bit word, modulus M in another), start a Montgomery product, and read back the result. Every command completes with a done/done_read handshake. Exponentiation opcodes are reserved in this revision and complete as no-ops.

---
 rtl/rsa_mont_wrapper.sv | 158 +++++++++++++++
 tb/tb_rsa_mont_wrapper.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_mont_wrapper.sv
// Host command wrapper around a bit-serial radix-2 Montgomery multiplier.
// Loads A/B and M over a wide bus, computes A*B*2^-N mod M, returns the result.
module rsa_mont_wrapper #(
  parameter int N     = 512,
  parameter int BUS_W = 1024
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      arm_to_fpga_cmd,
  input  logic             arm_to_fpga_cmd_valid,
  output logic             fpga_to_arm_done,
  input  logic             fpga_to_arm_done_read,
  input  logic             arm_to_fpga_data_valid,
  output logic             arm_to_fpga_data_ready,
  input  logic [BUS_W-1:0] arm_to_fpga_data,
  output logic             fpga_to_arm_data_valid,
  input  logic             fpga_to_arm_data_ready,
  output logic [BUS_W-1:0] fpga_to_arm_data,
  output logic [3:0]       leds
);

  localparam int CW = $clog2(N + 2);
  localparam int AW = $clog2(N);
  localparam logic [CW-1:0] CNT_SUB = CW'(N);

  localparam logic [2:0] OP_READ_AB      = 3'd1;
  localparam logic [2:0] OP_READ_M       = 3'd2;
  localparam logic [2:0] OP_COMPUTE_MONT = 3'd4;
  localparam logic [2:0] OP_WRITE        = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_COMPUTE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          r_state;
  logic [2:0]      r_opcode;
  logic            r_done;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_m;
  logic [N-1:0]    r_res;
  logic [N-1:0]    r_out;
  logic [N+1:0]    r_c;
  logic [CW-1:0]   r_cnt;

  logic [AW-1:0]   w_idx;
  logic            w_a_bit;
  logic [N+1:0]    w_sum1;
  logic [N+1:0]    w_sum2;
  logic [N+1:0]    w_shift;
  logic [N+1:0]    w_sub;
  logic            w_unused;

  // One Montgomery iteration: add a_i*B, make even by adding M, halve.
  assign w_idx   = r_cnt[AW-1:0];
  assign w_a_bit = r_a[w_idx];
  assign w_sum1  = r_c + (w_a_bit ? {2'b00, r_b} : '0);
  assign w_sum2  = w_sum1 + (w_sum1[0] ? {2'b00, r_m} : '0);
  assign w_shift = {1'b0, w_sum2[N+1:1]};
  assign w_sub   = (r_c >= {2'b00, r_m}) ? (r_c - {2'b00, r_m}) : r_c;

  assign arm_to_fpga_data_ready = (r_state == S_READ) && arm_to_fpga_data_valid;
  assign fpga_to_arm_data_valid = (r_state == S_WRITE) && fpga_to_arm_data_ready;
  assign fpga_to_arm_data       = {{(BUS_W-N){1'b0}}, r_out};
  assign fpga_to_arm_done       = r_done;
  assign leds                   = {1'b0, r_state};

  assign w_unused = ^{arm_to_fpga_cmd[31:3], w_sum2[0]};

  // NOTE: state is updated only with non-blocking assignments so every branch
  // reads the pre-edge values; the operand registers are cleared on reset
  // because a WRITE before any compute must return zero.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state  <= S_IDLE;
      r_opcode <= '0;
      r_done   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_res    <= '0;
      r_out    <= '0;
      r_c      <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (arm_to_fpga_cmd_valid) begin
            r_opcode <= arm_to_fpga_cmd[2:0];
            case (arm_to_fpga_cmd[2:0])
              OP_READ_AB, OP_READ_M: r_state <= S_READ;
              OP_COMPUTE_MONT: begin
                r_state <= S_COMPUTE;
                r_c     <= '0;
                r_cnt   <= '0;
              end
              OP_WRITE: begin
                r_state <= S_WRITE;
                r_out   <= r_res;
              end
              default: begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            endcase
          end
        end
        S_READ: begin
          if (arm_to_fpga_data_valid) begin
            if (r_opcode == OP_READ_AB) begin
              r_a <= arm_to_fpga_data[N-1:0];
              r_b <= arm_to_fpga_data[2*N-1:N];
            end else begin
              r_m <= arm_to_fpga_data[N-1:0];
            end
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_COMPUTE: begin
          // N iterations, one conditional subtract, then a result store cycle.
          if (r_cnt < CNT_SUB) begin
            r_c   <= w_shift;
            r_cnt <= r_cnt + CW'(1);
          end else if (r_cnt == CNT_SUB) begin
            r_c   <= w_sub;
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_res   <= r_c[N-1:0];
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_WRITE: begin
          if (fpga_to_arm_data_ready) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (fpga_to_arm_done_read) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_mont_wrapper.sv
// Scoreboard bench for rsa_mont_wrapper: results predicted with an
// independent wide-arithmetic model (A*B mod M times 2^-512 mod M).
module tb_rsa_mont_wrapper;

  logic          clk;
  logic          resetn;
  logic [31:0]   arm_to_fpga_cmd;
  logic          arm_to_fpga_cmd_valid;
  logic          fpga_to_arm_done;
  logic          fpga_to_arm_done_read;
  logic          arm_to_fpga_data_valid;
  logic          arm_to_fpga_data_ready;
  logic [1023:0] arm_to_fpga_data;
  logic          fpga_to_arm_data_valid;
  logic          fpga_to_arm_data_ready;
  logic [1023:0] fpga_to_arm_data;
  logic [3:0]    leds;

  rsa_mont_wrapper dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .arm_to_fpga_cmd        (arm_to_fpga_cmd),
    .arm_to_fpga_cmd_valid  (arm_to_fpga_cmd_valid),
    .fpga_to_arm_done       (fpga_to_arm_done),
    .fpga_to_arm_done_read  (fpga_to_arm_done_read),
    .arm_to_fpga_data_valid (arm_to_fpga_data_valid),
    .arm_to_fpga_data_ready (arm_to_fpga_data_ready),
    .arm_to_fpga_data       (arm_to_fpga_data),
    .fpga_to_arm_data_valid (fpga_to_arm_data_valid),
    .fpga_to_arm_data_ready (fpga_to_arm_data_ready),
    .fpga_to_arm_data       (fpga_to_arm_data),
    .leds                   (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [1023:0] sb_q[$];
  logic [511:0]  m_a, m_b, m_m, m_res;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mont_ref(input logic [511:0] a, input logic [511:0] b,
                                            input logic [511:0] m);
    logic [1023:0] mm, x, h;
    mm = {512'b0, m};
    x  = ({512'b0, a} * {512'b0, b}) % mm;
    h  = (mm + 1024'd1) >> 1;           // inverse of 2 modulo an odd m
    repeat (9) h = (h * h) % mm;         // 2^-512 mod m
    x  = (x * h) % mm;
    return x[511:0];
  endfunction

  function automatic logic [1023:0] rand_wide();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic send_cmd(input logic [2:0] op);
    @(negedge clk);
    arm_to_fpga_cmd       = {29'($urandom()), op};
    arm_to_fpga_cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    arm_to_fpga_cmd_valid = 1'b0;
  endtask

  task automatic ack_done(input string tag);
    check({tag, "_done"}, 512'(fpga_to_arm_done), 512'd1);
    @(negedge clk);
    fpga_to_arm_done_read = 1'b1;
    @(posedge clk);
    #1;
    fpga_to_arm_done_read = 1'b0;
    check({tag, "_fall"}, 512'(fpga_to_arm_done), 512'd0);
    check({tag, "_idle"}, 512'(leds), 512'd0);
  endtask

  task automatic wait_done(input string tag, input int budget, output int lat);
    lat = 0;
    while (!fpga_to_arm_done && lat < budget) begin
      @(posedge clk);
      #1;
      lat++;
    end
    ack_done(tag);
  endtask

  task automatic load_ab(input logic [511:0] a, input logic [511:0] b);
    int lat;
    send_cmd(3'd1);
    arm_to_fpga_data       = {b, a};
    arm_to_fpga_data_valid = 1'b1;
    #1;
    check("ab_ready", 512'(arm_to_fpga_data_ready), 512'd1);
    wait_done("ab", 10, lat);
    arm_to_fpga_data_valid = 1'b0;
    m_a = a;
    m_b = b;
  endtask

  task automatic load_m(input logic [511:0] m);
    int lat;
    send_cmd(3'd2);
    arm_to_fpga_data       = {rand_wide() >> 512, 512'b0} | {512'b0, m};
    arm_to_fpga_data_valid = 1'b1;
    wait_done("m", 10, lat);
    arm_to_fpga_data_valid = 1'b0;
    m_m = m;
  endtask

  task automatic compute(input bit inject);
    int lat;
    send_cmd(3'd4);
    m_res = mont_ref(m_a, m_b, m_m);
    lat = 0;
    while (!fpga_to_arm_done && lat < 1000) begin
      if (inject && lat == 50) begin
        arm_to_fpga_cmd        = 32'd1;
        arm_to_fpga_cmd_valid  = 1'b1;
        arm_to_fpga_data       = rand_wide();
        arm_to_fpga_data_valid = 1'b1;
        #1;
        check("busy_ready", 512'(arm_to_fpga_data_ready), 512'd0);
      end
      @(posedge clk);
      #1;
      arm_to_fpga_cmd_valid  = 1'b0;
      arm_to_fpga_data_valid = 1'b0;
      lat++;
    end
    check("latency", 512'(lat), 512'd514);
    ack_done("cmp");
  endtask

  task automatic write_out(input int stall);
    int k;
    int bad;
    logic [1023:0] exp;
    fpga_to_arm_data_ready = (stall == 0);
    send_cmd(3'd5);
    sb_q.push_back({512'b0, m_res});
    bad = 0;
    repeat (stall) begin
      if (fpga_to_arm_data_valid !== 1'b0 || leds !== 4'd3) bad++;
      @(posedge clk);
      #1;
    end
    if (stall > 0) check("stall", 512'(bad), 512'd0);
    fpga_to_arm_data_ready = 1'b1;
    #1;
    k = 0;
    while (!fpga_to_arm_data_valid && k < 8) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("wr_valid", 512'(fpga_to_arm_data_valid), 512'd1);
    if (sb_q.size() == 0) begin
      check("sb_empty", 512'(sb_q.size()), 512'd1);
    end else begin
      exp = sb_q.pop_front();
      check("wr_lo", fpga_to_arm_data[511:0], exp[511:0]);
      check("wr_hi", fpga_to_arm_data[1023:512], exp[1023:512]);
    end
    @(posedge clk);
    #1;
    check("wr_one", 512'(fpga_to_arm_data_valid), 512'd0);
    ack_done("wr");
  endtask

  task automatic noop(input logic [2:0] op);
    int lat;
    arm_to_fpga_data_valid = 1'b1;
    arm_to_fpga_data       = rand_wide();
    send_cmd(op);
    #1;
    check("noop_ready", 512'(arm_to_fpga_data_ready), 512'd0);
    wait_done("noop", 4, lat);
    check("noop_lat", 512'(lat), 512'd0);
    arm_to_fpga_data_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    resetn                 = 1'b1;
    arm_to_fpga_cmd        = '0;
    arm_to_fpga_cmd_valid  = 1'b0;
    fpga_to_arm_done_read  = 1'b0;
    arm_to_fpga_data_valid = 1'b1;
    arm_to_fpga_data       = '0;
    fpga_to_arm_data_ready = 1'b1;
    m_a = '0; m_b = '0; m_m = '0; m_res = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", 512'(fpga_to_arm_done), 512'd0);
    check("rst_ready", 512'(arm_to_fpga_data_ready), 512'd0);
    check("rst_valid", 512'(fpga_to_arm_data_valid), 512'd0);
    check("rst_leds", 512'(leds), 512'd0);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_ready", 512'(arm_to_fpga_data_ready), 512'd0);
    check("idle_valid", 512'(fpga_to_arm_data_valid), 512'd0);
    arm_to_fpga_data_valid = 1'b0;

    write_out(0);                       // nothing computed yet: zero

    load_ab(512'd3, 512'd5);
    load_m(512'd7);
    compute(1'b0);
    write_out(0);

    load_ab(512'd2, 512'd2);
    load_m(512'd3);
    compute(1'b0);
    write_out(0);

    load_ab(512'd0, 512'd123456789);
    load_m(512'd7);
    compute(1'b0);
    write_out(0);

    load_ab(512'h0ddc0ffee1234567_89abcdef01234567_89abcdef01234567_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0_1122334455667788_99aabbccdd0a118d,
            512'h12887b5a5a5a5a5a_0123456789abcdef_deadbeefcafebabe_0011223344556677_8899aabbccddeeff_7766554433221100_0f0f0f0f0f0f0f0f_f0f0f0f0f0f0f0f1);
    load_m(512'hf8f635bf0a1b2c3d_4e5f60718293a4b5_c6d7e8f90a1b2c3d_4e5f607182930011_2233445566778899_aabbccddeeff0011_1357913579135791_2468024680ac997d);
    compute(1'b0);
    write_out(0);
    write_out(20);                      // stalled host, same result again

    noop(3'd0);
    noop(3'd3);
    noop(3'd7);
    write_out(0);                       // result unchanged by no-ops
    compute(1'b0);                      // operands unchanged by no-ops
    write_out(0);

    load_ab(512'd4, 512'd6);
    load_m(512'd11);
    compute(1'b1);                      // stray command mid-compute
    write_out(0);

    send_cmd(3'd4);
    repeat (100) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_leds", 512'(leds), 512'd0);
    @(negedge clk);
    resetn = 1'b0;
    m_a = '0; m_b = '0; m_m = '0; m_res = '0;
    seen = 0;
    repeat (600) begin
      @(posedge clk);
      #1;
      if (fpga_to_arm_done) seen++;
    end
    check("abort_nodone", 512'(seen), 512'd0);
    write_out(0);                       // cleared by reset

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
